// File: rtl/bsg_upstream_credit_piso.sv
// Credit-gated upstream serialiser: one core word becomes B beats
// on CH_N channels of CH_W bits each. Token toggles return credits.
module bsg_upstream_credit_piso #(
  parameter int WORD_W    = 64,
  parameter int CH_N      = 2,
  parameter int CH_W      = 8,
  parameter int CREDITS   = 16,
  parameter int TOKEN_DEC = 8,
  parameter int CNT_W     = 7,
  localparam int BW  = CH_N * CH_W,
  localparam int CRW = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_valid_i,
  input  logic [WORD_W-1:0] core_data_i,
  output logic              core_ready_o,
  input  logic              io_token_i,
  output logic              io_valid_o,
  output logic [BW-1:0]     io_data_o,
  output logic [CRW-1:0]    credits_o,
  output logic [CNT_W-1:0]  sent_cnt_o,
  output logic [CNT_W-1:0]  finish_cnt_o,
  output logic              credit_overflow_o
);

  localparam int B   = WORD_W / BW;
  localparam int BTW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state, state_n;
  logic [BTW-1:0]    beat, beat_n;
  logic [WORD_W-1:0] shreg;
  logic [CRW-1:0]    credits;
  logic              token_r;
  logic              toggle;
  logic              last;
  logic              accept;
  logic [CRW:0]      cred_sum;

  assign last   = (state == SHIFT) && (beat == BTW'(B - 1));
  assign toggle = io_token_i ^ token_r;

  assign core_ready_o = (credits != '0) &&
                        ((state == IDLE) || last);
  assign accept       = core_valid_i && core_ready_o;

  assign io_valid_o   = (state == SHIFT);
  assign io_data_o    = (state == SHIFT) ? shreg[BW-1:0] : '0;

  assign credits_o    = credits;

  // State and beat counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  // Next state: a last-beat accept reloads without an idle gap
  always_comb begin
    state_n = state;
    beat_n  = beat;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          beat_n  = '0;
        end
      end
      SHIFT: begin
        if (last) begin
          state_n = accept ? SHIFT : IDLE;
          beat_n  = '0;
        end else begin
          beat_n = beat + BTW'(1);
        end
      end
    endcase
  end

  // Shift register presents the LS slice and drops it each beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= core_data_i;
    end else if (state == SHIFT) begin
      shreg <= shreg >> BW;
    end
  end

  // One spare bit so a return past the ceiling is visible
  always_comb begin
    cred_sum = {1'b0, credits}
             + (toggle ? (CRW+1)'(TOKEN_DEC) : '0)
             - (CRW+1)'(accept);
  end

  // Credits, token edge detect, counters and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits           <= CRW'(CREDITS);
      token_r           <= 1'b0;
      sent_cnt_o        <= '0;
      finish_cnt_o      <= '0;
      credit_overflow_o <= 1'b0;
    end else begin
      token_r <= io_token_i;
      if (cred_sum > (CRW+1)'(CREDITS)) begin
        credits           <= CRW'(CREDITS);
        credit_overflow_o <= 1'b1;
      end else begin
        credits <= cred_sum[CRW-1:0];
      end
      if (accept)
        sent_cnt_o <= sent_cnt_o + CNT_W'(1);
      if (toggle)
        finish_cnt_o <= finish_cnt_o + CNT_W'(TOKEN_DEC);
    end
  end

endmodule

// File: tb/tb_bsg_upstream_credit_piso.sv
// Bench for bsg_upstream_credit_piso: directed scenarios plus a
// random run against a queue-based beat/credit model.
module tb_bsg_upstream_credit_piso;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_valid = 1'b0;
  logic [63:0] core_data = '0;
  logic        core_ready;
  logic        io_token = 1'b0;
  logic        io_valid;
  logic [15:0] io_data;
  logic [4:0]  credits;
  logic [6:0]  sent_cnt;
  logic [6:0]  finish_cnt;
  logic        ovf;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  bsg_upstream_credit_piso dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_valid_i      (core_valid),
    .core_data_i       (core_data),
    .core_ready_o      (core_ready),
    .io_token_i        (io_token),
    .io_valid_o        (io_valid),
    .io_data_o         (io_data),
    .credits_o         (credits),
    .sent_cnt_o        (sent_cnt),
    .finish_cnt_o      (finish_cnt),
    .credit_overflow_o (ovf)
  );

  // Reference model: queue of beats still owed, plain credit count
  logic [15:0] m_q[$];
  int          m_cred = 16;
  int          m_sent = 0;
  int          m_fin = 0;
  bit          m_ovf = 0;
  bit          m_tokp = 0;
  bit          m_acc = 0;

  logic        exp_ready, exp_valid, exp_ovf;
  logic [15:0] exp_data;
  logic [4:0]  exp_cred;
  logic [6:0]  exp_sent, exp_fin;

  logic        obs_ready, obs_valid, obs_ovf;
  logic [15:0] obs_data;
  logic [4:0]  obs_cred;
  logic [6:0]  obs_sent, obs_fin;

  task automatic cyc(input bit v, input logic [63:0] d,
                     input bit t, input bit r);
    bit tog;
    int nxt;
    @(negedge clk);
    core_valid = v;
    core_data  = d;
    io_token   = t;
    rst_n      = r;
    #1;
    exp_ready = (m_cred > 0) && (m_q.size() <= 1);
    exp_valid = (m_q.size() > 0);
    exp_data  = exp_valid ? m_q[0] : 16'h0;
    exp_cred  = 5'(m_cred);
    exp_sent  = 7'(m_sent);
    exp_fin   = 7'(m_fin);
    exp_ovf   = m_ovf;
    obs_ready = core_ready;
    obs_valid = io_valid;
    obs_data  = io_data;
    obs_cred  = credits;
    obs_sent  = sent_cnt;
    obs_fin   = finish_cnt;
    obs_ovf   = ovf;
    m_acc = v && exp_ready;
    if (!r) begin
      m_q.delete();
      m_cred = 16;
      m_sent = 0;
      m_fin  = 0;
      m_ovf  = 0;
      m_tokp = 0;
    end else begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (m_acc)
        for (int i = 0; i < 4; i++) m_q.push_back(d[16*i +: 16]);
      tog    = t ^ m_tokp;
      m_tokp = t;
      nxt = m_cred + (tog ? 8 : 0) - (m_acc ? 1 : 0);
      if (nxt > 16) begin
        m_cred = 16;
        m_ovf  = 1;
      end else begin
        m_cred = nxt;
      end
      m_sent += m_acc ? 1 : 0;
      m_fin  += tog ? 8 : 0;
    end
  endtask

  task automatic do_reset();
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
  endtask

  task automatic send_words(input int n);
    while (m_sent < n || m_q.size() > 0)
      cyc(m_sent < n, {$urandom, $urandom}, m_tokp, 1);
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, '0, 0, 1);
    nchk++;
    if (obs_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_ready got %b want 1", obs_ready);
    end
    nchk++;
    if (obs_valid !== 1'b0 || obs_data !== 16'h0) begin
      nfail++;
      $display("FAIL reset_io got v=%b d=%h want 0/0",
               obs_valid, obs_data);
    end
    nchk++;
    if (obs_cred !== 5'd16) begin
      nfail++;
      $display("FAIL reset_credits got %0d want 16", obs_cred);
    end
    nchk++;
    if (obs_sent !== 7'd0 || obs_fin !== 7'd0 || obs_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL reset_cnt got s=%0d f=%0d o=%b want 0",
               obs_sent, obs_fin, obs_ovf);
    end
  endtask

  task automatic test_single();
    logic [15:0] want[4];
    want[0] = 16'hCDEF;
    want[1] = 16'h89AB;
    want[2] = 16'h4567;
    want[3] = 16'h0123;
    do_reset();
    cyc(1, 64'h0123456789ABCDEF, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 0, 1);
      nchk++;
      if (obs_valid !== 1'b1 || obs_data !== want[i]) begin
        nfail++;
        $display("FAIL single_beat%0d got v=%b d=%h want 1/%h",
                 i, obs_valid, obs_data, want[i]);
      end
    end
    cyc(0, '0, 0, 1);
    nchk++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      nfail++;
      $display("FAIL single_idle got v=%b r=%b want 0/1",
               obs_valid, obs_ready);
    end
    nchk++;
    if (obs_cred !== 5'd15 || obs_sent !== 7'd1) begin
      nfail++;
      $display("FAIL single_cnt got c=%0d s=%0d want 15/1",
               obs_cred, obs_sent);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w[4];
    int acc_at[$];
    for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
    do_reset();
    for (int c = 0; c < 13; c++) begin
      cyc(c <= 8, w[acc_at.size() > 3 ? 3 : acc_at.size()], 0, 1);
      if (core_valid && obs_ready) acc_at.push_back(c);
      if (c >= 1) begin
        nchk++;
        if (obs_valid !== 1'b1 || obs_data !== exp_data) begin
          nfail++;
          $display("FAIL b2b_beat c=%0d got v=%b d=%h want 1/%h",
                   c, obs_valid, obs_data, exp_data);
        end
      end
    end
    nchk++;
    if (acc_at.size() != 3 || acc_at[0] != 0 ||
        acc_at[1] != 4 || acc_at[2] != 8) begin
      nfail++;
      $display("FAIL b2b_accepts got n=%0d want 3 at 0,4,8",
               acc_at.size());
    end
    cyc(0, '0, 0, 1);
    nchk++;
    if (obs_valid !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_end got v=%b want 0", obs_valid);
    end
  endtask

  task automatic test_exhaust();
    int nacc = 0;
    do_reset();
    for (int c = 0; c < 67; c++) begin
      cyc(1, {$urandom, $urandom}, 0, 1);
      if (obs_ready) nacc++;
      nchk++;
      if (obs_valid !== exp_valid || obs_ready !== exp_ready ||
          obs_data !== exp_data) begin
        nfail++;
        $display("FAIL exh_cycle c=%0d got v=%b r=%b d=%h want %b/%b/%h",
                 c, obs_valid, obs_ready, obs_data,
                 exp_valid, exp_ready, exp_data);
      end
    end
    nchk++;
    if (nacc != 16) begin
      nfail++;
      $display("FAIL exh_accepts got %0d want 16", nacc);
    end
    nchk++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b0) begin
      nfail++;
      $display("FAIL exh_stall got r=%b v=%b want 0/0",
               obs_ready, obs_valid);
    end
    nchk++;
    if (obs_cred !== 5'd0 || obs_sent !== 7'd16) begin
      nfail++;
      $display("FAIL exh_cnt got c=%0d s=%0d want 0/16",
               obs_cred, obs_sent);
    end
  endtask

  task automatic test_token();
    cyc(0, '0, 1, 1);
    nchk++;
    if (obs_ready !== 1'b0) begin
      nfail++;
      $display("FAIL tok_same_cycle got r=%b want 0", obs_ready);
    end
    cyc(0, '0, 1, 1);
    nchk++;
    if (obs_cred !== 5'd8 || obs_fin !== 7'd8 || obs_ready !== 1'b1) begin
      nfail++;
      $display("FAIL tok_rise got c=%0d f=%0d r=%b want 8/8/1",
               obs_cred, obs_fin, obs_ready);
    end
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    nchk++;
    if (obs_fin !== 7'd16 || obs_cred !== 5'd16) begin
      nfail++;
      $display("FAIL tok_fall got f=%0d c=%0d want 16/16",
               obs_fin, obs_cred);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_words(6);
    cyc(1, {$urandom, $urandom}, 1, 1);
    nchk++;
    if (obs_cred !== 5'd10) begin
      nfail++;
      $display("FAIL ovf_pre got c=%0d want 10", obs_cred);
    end
    cyc(0, '0, 1, 1);
    nchk++;
    if (obs_cred !== 5'd16 || obs_ovf !== 1'b1 || obs_sent !== 7'd7) begin
      nfail++;
      $display("FAIL ovf_sat got c=%0d o=%b s=%0d want 16/1/7",
               obs_cred, obs_ovf, obs_sent);
    end
    send_words(0);
    cyc(0, '0, 1, 1);
    nchk++;
    if (obs_ovf !== 1'b1) begin
      nfail++;
      $display("FAIL ovf_sticky got o=%b want 1", obs_ovf);
    end
    do_reset();
    send_words(8);
    cyc(1, {$urandom, $urandom}, 1, 1);
    cyc(0, '0, 1, 1);
    nchk++;
    if (obs_cred !== 5'd15 || obs_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL ovf_none got c=%0d o=%b want 15/0",
               obs_cred, obs_ovf);
    end
    send_words(0);
  endtask

  task automatic test_midreset();
    logic [63:0] w2;
    w2 = {$urandom, $urandom};
    do_reset();
    cyc(1, 64'h0123456789ABCDEF, 0, 1);
    cyc(0, '0, 1, 1);
    cyc(0, '0, 0, 0);
    nchk++;
    if (obs_data !== 16'h89AB || obs_fin !== 7'd8) begin
      nfail++;
      $display("FAIL mid_pre got d=%h f=%0d want 89ab/8",
               obs_data, obs_fin);
    end
    cyc(0, '0, 0, 1);
    nchk++;
    if (obs_valid !== 1'b0 || obs_cred !== 5'd16 ||
        obs_sent !== 7'd0 || obs_fin !== 7'd0) begin
      nfail++;
      $display("FAIL mid_abort got v=%b c=%0d s=%0d f=%0d want 0/16/0/0",
               obs_valid, obs_cred, obs_sent, obs_fin);
    end
    cyc(1, w2, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 0, 1);
      nchk++;
      if (obs_valid !== 1'b1 || obs_data !== w2[16*i +: 16]) begin
        nfail++;
        $display("FAIL mid_new%0d got v=%b d=%h want 1/%h",
                 i, obs_valid, obs_data, w2[16*i +: 16]);
      end
    end
    cyc(0, '0, 0, 1);
    nchk++;
    if (obs_valid !== 1'b0) begin
      nfail++;
      $display("FAIL mid_end got v=%b want 0", obs_valid);
    end
  endtask

  task automatic test_random();
    bit tk = 0;
    bit r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      r = !(c == 400 || c == 401);
      if (!r) tk = 0;
      else if ($urandom_range(0, 9) == 0) tk = !tk;
      cyc($urandom_range(0, 9) < 7, {$urandom, $urandom}, tk, r);
      nchk++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid ||
          obs_data !== exp_data) begin
        nfail++;
        $display("FAIL rnd_io c=%0d got r=%b v=%b d=%h want %b/%b/%h",
                 c, obs_ready, obs_valid, obs_data,
                 exp_ready, exp_valid, exp_data);
      end
      nchk++;
      if (obs_cred !== exp_cred || obs_ovf !== exp_ovf) begin
        nfail++;
        $display("FAIL rnd_cred c=%0d got c=%0d o=%b want %0d/%b",
                 c, obs_cred, obs_ovf, exp_cred, exp_ovf);
      end
      nchk++;
      if (obs_sent !== exp_sent || obs_fin !== exp_fin) begin
        nfail++;
        $display("FAIL rnd_cnt c=%0d got s=%0d f=%0d want %0d/%0d",
                 c, obs_sent, obs_fin, exp_sent, exp_fin);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_exhaust();
    test_token();
    test_overflow();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
